// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        CMD,
        FILL
    } state_e;

    localparam logic [2:0] CMD_READ = 3'b001;

    function automatic int offsetWidth(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int indexWidth(input int numLines);
        return $clog2(numLines);
    endfunction

    function automatic int tagWidth(input int addrW, input int lineWords, input int numLines);
        return addrW - 2 - $clog2(lineWords) - $clog2(numLines);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one write port, one synchronous read port, no reset so it maps to block RAM.
module icache_data_ram #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache; misses fetch a whole line with one DRAM burst.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          LINE_WORDS = 8,
    parameter int          NUM_LINES  = 16,
    parameter logic [29:0] MEM_BASE   = 30'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done_i,
    input  logic              flush_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_valid_o,
    output logic [31:0]       fetch_data_o,
    output logic              busy_o,
    output logic              err_o,
    output logic              mem_cmd_en_o,
    output logic [2:0]        mem_cmd_instr_o,
    output logic [5:0]        mem_cmd_bl_o,
    output logic [29:0]       mem_cmd_byte_addr_o,
    input  logic              mem_cmd_empty_i,
    input  logic              mem_cmd_full_i,
    output logic              mem_rd_en_o,
    input  logic [31:0]       mem_rd_data_i,
    input  logic              mem_rd_full_i,
    input  logic              mem_rd_empty_i,
    input  logic              mem_rd_overflow_i,
    input  logic              mem_rd_error_i,
    input  logic [6:0]        mem_rd_count_i
);

    localparam int OFFSET_W = offsetWidth(LINE_WORDS);
    localparam int INDEX_W  = indexWidth(NUM_LINES);
    localparam int TAG_W    = tagWidth(ADDR_W, LINE_WORDS, NUM_LINES);
    localparam int RAM_AW   = OFFSET_W + INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    state_e              state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]    tags_q [NUM_LINES];
    logic [TAG_W-1:0]    reqTag_q;
    logic [INDEX_W-1:0]  reqIndex_q;
    logic [OFFSET_W-1:0] fillCnt_q;
    logic                poison_q;
    logic                err_q;
    logic [31:0]         fetchData_q;
    logic [29:0]         cmdAddr_q;

    logic [TAG_W-1:0]    addrTag;
    logic [INDEX_W-1:0]  addrIndex;
    logic [OFFSET_W-1:0] addrOffset;
    logic [ADDR_W-1:0]   lineAddr;
    logic [31:0]         ramData;
    logic                startLookup;
    logic                hit;
    logic                lookupHit;
    logic                fillDone;
    logic                poison_d;
    logic                unused_inputs;

    assign {addrTag, addrIndex, addrOffset} = fetch_addr_i[ADDR_W-1:2];
    assign lineAddr = {reqTag_q, reqIndex_q, {(OFFSET_W + 2){1'b0}}};

    assign startLookup = (state_q == IDLE) && boot_done_i && fetch_req_i;
    assign hit         = valid_q[reqIndex_q] && (tags_q[reqIndex_q] == reqTag_q);
    assign lookupHit   = (state_q == LOOKUP) && hit;
    assign mem_rd_en_o = (state_q == FILL) && !mem_rd_empty_i;
    assign fillDone    = mem_rd_en_o && (fillCnt_q == LAST_WORD);
    // Events in the current cycle count too, so a fault on the last word still poisons the line.
    assign poison_d    = poison_q | flush_i | mem_rd_error_i | mem_rd_overflow_i;

    assign fetch_valid_o       = lookupHit;
    assign fetch_data_o        = lookupHit ? ramData : fetchData_q;
    assign mem_cmd_en_o        = (state_q == CMD) && !mem_cmd_full_i;
    assign mem_cmd_instr_o     = CMD_READ;
    assign mem_cmd_bl_o        = 6'(LINE_WORDS - 1);
    assign mem_cmd_byte_addr_o = cmdAddr_q;
    assign busy_o              = (state_q == CMD) || (state_q == FILL);
    assign err_o               = err_q;

    assign unused_inputs = ^{mem_cmd_empty_i, mem_rd_full_i, mem_rd_count_i, fetch_addr_i[1:0]};

    icache_data_ram #(
        .AW(RAM_AW)
    ) u_data_ram (
        .clk    (clk),
        .we_i   (mem_rd_en_o),
        .waddr_i({reqIndex_q, fillCnt_q}),
        .wdata_i(mem_rd_data_i),
        .re_i   (startLookup),
        .raddr_i({addrIndex, addrOffset}),
        .rdata_o(ramData)
    );

    always_ff @(posedge clk) begin
        if (fillDone) begin
            tags_q[reqIndex_q] <= reqTag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            reqTag_q    <= '0;
            reqIndex_q  <= '0;
            fillCnt_q   <= '0;
            poison_q    <= 1'b0;
            err_q       <= 1'b0;
            fetchData_q <= '0;
            cmdAddr_q   <= '0;
        end else begin
            // Flush beats a same-cycle fill completion.
            if (flush_i) begin
                valid_q <= '0;
            end else if (fillDone && !poison_d) begin
                valid_q[reqIndex_q] <= 1'b1;
            end

            if ((state_q == FILL) && (mem_rd_error_i || mem_rd_overflow_i)) begin
                err_q <= 1'b1;
            end

            if (lookupHit) begin
                fetchData_q <= ramData;
            end

            case (state_q)
                IDLE: begin
                    if (startLookup) begin
                        reqTag_q   <= addrTag;
                        reqIndex_q <= addrIndex;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state_q <= IDLE;
                    end else begin
                        cmdAddr_q <= MEM_BASE + 30'(lineAddr);
                        state_q   <= CMD;
                    end
                end
                CMD: begin
                    if (!mem_cmd_full_i) begin
                        fillCnt_q <= '0;
                        poison_q  <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    poison_q <= poison_d;
                    if (mem_rd_en_o) begin
                        fillCnt_q <= fillCnt_q + OFFSET_W'(1);
                    end
                    if (fillDone) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Parametrised, direct-mapped, read-only instruction cache between the CPU fetch stage and one read-only DRAM controller port (command FIFO plus read-data FIFO). On a miss it issues one burst read per cache line, fills the line from the read FIFO, then serves the fetch. It stays idle until boot loading completes, and supports whole-cache flush and error reporting.

## Interface
- ADDR_W, 16: CPU byte-address width.
- LINE_WORDS, 8: 32-bit words per line and burst length; power of 2, range 2..64.
- NUM_LINES, 16: number of cache lines; power of 2, at least 2.
- MEM_BASE, 30'h0: DRAM byte address of CPU address 0; line-aligned.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- boot_done  in  1  fetches are ignored while low.
- flush  in  1  one-cycle pulse; invalidates all lines.
- fetch_req  in  1  fetch request; held with fetch_addr until fetch_valid.
- fetch_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- fetch_valid  out  1  one-cycle pulse; fetch_data is valid.
- fetch_data  out  32  instruction word; holds its last value otherwise.
- busy  out  1  high in CMD or FILL.
- err  out  1  sticky read-error/overflow flag; cleared only by rst.
- mem_cmd_en  out  1; mem_cmd_instr  out  3  constant 3'b001 (read); mem_cmd_bl  out  6  constant LINE_WORDS-1; mem_cmd_byte_addr  out  30; mem_cmd_empty, mem_cmd_full  in  1.
- mem_rd_en  out  1; mem_rd_data  in  32; mem_rd_full, mem_rd_empty, mem_rd_overflow, mem_rd_error  in  1; mem_rd_count  in  7.

## Operation
- Address split of word address fetch_addr[ADDR_W-1:2]:
  - offset: low log2(LINE_WORDS) bits.
  - index: next log2(NUM_LINES) bits.
  - tag: the remaining bits. Defaults give 3/4/7 bits.
- Storage: per line a valid bit (register vector) and a tag. Data array holds NUM_LINES×LINE_WORDS words with synchronous read.
- Burst address: mem_cmd_byte_addr = MEM_BASE + zero-extended {tag, index, (log2(LINE_WORDS)+2) zeros}, modulo 2^30.
- FSM states: IDLE, LOOKUP, CMD, FILL.
  - IDLE: if boot_done and fetch_req, read the arrays and go to LOOKUP. Otherwise stay.
  - LOOKUP: on hit (valid and tag match), drive fetch_valid=1 and fetch_data=word, then go to IDLE. On miss, latch the line address and go to CMD.
  - CMD: while mem_cmd_full, wait. Otherwise assert mem_cmd_en for exactly one cycle, clear the fill counter, and go to FILL.
  - FILL: mem_rd_en = !mem_rd_empty. Each consumed word is written at the counter position, then the counter increments. After word LINE_WORDS-1, write the tag, set valid unless the fill is poisoned, and go to IDLE. The request is then re-looked-up.
- Poisoning: flush, mem_rd_error, or mem_rd_overflow during FILL marks the fill poisoned.
  - The burst is still fully drained, so exactly LINE_WORDS words are read.
  - The line is left invalid.
  - Error or overflow also sets err.
- flush clears all valid bits in the same cycle. If flush and the fill-complete valid set occur in the same cycle, flush wins.
- A fetch_req drop mid-miss does not abort the burst. The fill completes and the FSM returns to IDLE.
- Reset outputs and state:
  - mem_cmd_en=0, mem_rd_en=0, fetch_valid=0, fetch_data=0, busy=0, err=0.
  - All valid bits cleared; state IDLE; fill counter 0.
  - mem_cmd_bl and mem_cmd_instr are constants.
  - The DRAM controller is reset together with this block, so stale FIFO contents are not handled.

## Timing
- Hit: request sampled in IDLE at cycle t; fetch_valid at t+1. Throughput is one fetch per 2 cycles.
- Miss, minimum with no FIFO stalls: mem_cmd_en at t+2, fill t+3..t+LINE_WORDS+2, fetch_valid at t+LINE_WORDS+4 (t+12 with defaults).
- mem_rd_en is never asserted while mem_rd_empty is high. mem_cmd_en is never asserted while mem_cmd_full is high.
- At most one burst is outstanding.
- A word read in the final FILL cycle is visible to the LOOKUP that follows.

## Structure
- Package icache_pkg holds:
  - the state enum;
  - the constant CMD_READ=3'b001;
  - functions deriving OFFSET_W, INDEX_W and TAG_W from the parameters.
- Sub-module icache_data_ram: single write port, single synchronous read port, sized NUM_LINES*LINE_WORDS×32, so it infers block RAM.
- Tags and valid bits stay in the top level.

## Test plan
- Cold miss with defaults:
  - Fetch 0x0040 -> one mem_cmd_en, bl=7, byte_addr=0x40.
  - Feed 0xA0..0xA7 -> fetch_valid with 0xA0 at t+12.
  - Then fetch 0x0044 -> hit one cycle after request, data 0xA1, no mem_cmd_en.
- Conflict: after the above, fetch 0x0240 (same index, new tag) -> miss at byte_addr 0x240. A following fetch 0x0040 misses again.
- Backpressure:
  - mem_cmd_full high for 5 cycles -> mem_cmd_en stays low, then pulses once.
  - mem_rd_empty toggling -> exactly 8 mem_rd_en cycles, each with empty=0.
- Flush after 3 fill words -> remaining 5 words drained, line invalid, a second burst to the same address is issued, and fetch_valid returns correct data.
- mem_rd_error pulse mid-fill -> err stays 1, line refilled on re-lookup, err persists until rst.
- boot_done=0 with fetch_req held -> no mem_cmd_en and no fetch_valid. Asserting rst mid-FILL -> all outputs return to reset values immediately.
